port_grant_2_vc_grant: RTL and testbench
========================================

# port_grant_2_vc_grant

Maps switch-allocation grants back onto the input virtual channels that produced them. It sits between the switch allocator and the input VC buffers, on the return path of `vc_req_2_port_req`. Per input VC it records the output VC won in VC allocation, and holds that binding until the packet's tail flit is sent. Each cycle it turns a per-port switch grant into one registered per-VC send grant, using a round-robin pointer per input port.

## Interface
- `NUM_PORTS`, default 2, number of router ports, used for both inputs and outputs.
- `NUM_VC`, default 2, number of VCs per port.
- Derived `TOTAL = NUM_PORTS*NUM_VC` and `IDXW = $clog2(TOTAL)`. Flat VC index = port*NUM_VC + vc. The output port of output VC j is j / NUM_VC.

Ports:
- `clk`  in  1  single clock for all state.
- `reset`  in  1  synchronous, active-high.
- `vc_grants`  in  [TOTAL-1:0][TOTAL-1:0]  VC-allocator grants. Row i is the grant to input VC i. Bit j set means input VC i won output VC j. Rows are one-hot or zero.
- `vc_ready`  in  [TOTAL-1:0]  input VC has a head-of-queue flit and downstream credit.
- `tail`  in  [TOTAL-1:0]  the head-of-queue flit of that VC is a tail flit.
- `port_grant`  in  [NUM_PORTS-1:0][NUM_PORTS-1:0]  switch grant. Row p is for input port p. Bit o set means input port p won output port o.
- `vc_sa_grant`  out  [TOTAL-1:0]  registered. Input VC i sends its flit this cycle.
- `vc_out_sel`  out  [TOTAL-1:0][IDXW-1:0]  output VC bound to each input VC.
- `vc_active`  out  [TOTAL-1:0]  input VC holds a binding.

## Operation
Per-VC state is IDLE or ACTIVE.
- **IDLE → ACTIVE:** when `vc_grants[i]` is nonzero:
  - `vc_out_sel[i]` ← index of the lowest set bit.
  - `vc_active[i]` ← 1.
- **ACTIVE:** `vc_grants[i]` is ignored.
- **ACTIVE → IDLE:** on the edge that registers `vc_sa_grant[i]` = 1 with `tail[i]` = 1.
  - `vc_out_sel[i]` keeps its last value.
- **Selection, per input port p:**
  - o = lowest set bit of `port_grant[p]`. A row of zero means no grant.
  - Candidates are VCs v of port p with `vc_active` = 1, `vc_ready` = 1 and `vc_out_sel[v]` / NUM_VC == o.
  - Search starts at `rr_ptr[p]` and wraps modulo NUM_VC. The first candidate wins.
- **Pointer update:**
  - A winner v exists: `rr_ptr[p]` ← (v+1) mod NUM_VC.
  - No winner: pointer unchanged.
- **Grant count:** at most one bit of `vc_sa_grant` per input port is set in any cycle.
- **Reset values:** all VCs IDLE, `vc_active` = 0, `vc_out_sel` = 0, `vc_sa_grant` = 0, all `rr_ptr` = 0.

## Timing
- **Binding latency:** `vc_grants` sampled at edge N → `vc_active` / `vc_out_sel` visible after edge N.
  - A binding captured at edge N can drive selection from the cycle after edge N.
- **Grant latency:** `port_grant` / `vc_ready` / `tail` sampled at edge N → `vc_sa_grant` valid for exactly one cycle after edge N.
  - No combinational path from any input to any output.
- **Tail release:** the tail grant and the release register on the same edge.
  - A `vc_grants` row arriving in that same cycle is ignored, because the VC was ACTIVE when sampled.
  - The next nonzero row is captured one edge later.
- **Mismatched grant:** a granted output port that matches no candidate gives no grant, and `rr_ptr` holds.
- **Reset:** `reset` high at an edge overrides every other update. Asserted mid-packet, it clears all bindings and any pending grant in that edge.

## Test plan
Configuration: NUM_PORTS=2, NUM_VC=2.
- **Reset:** hold `reset` 2 cycles with random inputs → `vc_sa_grant` = 4'b0000, `vc_active` = 4'b0000, all `vc_out_sel` = 0.
- **Capture:** `vc_grants[0]` = 4'b0001 and `vc_grants[1]` = 4'b0100 for one cycle → next cycle `vc_active` = 4'b0011, `vc_out_sel[0]` = 0, `vc_out_sel[1]` = 2.
- **Port match:** from the Capture state, drive `vc_ready` = 4'b0011 and `port_grant[0]` = 2'b10 → next cycle `vc_sa_grant` = 4'b0010.
  - Then drive `port_grant[0]` = 2'b00 → `vc_sa_grant` = 4'b0000.
- **Round-robin:** bind VC0→out VC0 and VC1→out VC1. Hold `vc_ready` = 4'b0011 and `port_grant[0]` = 2'b01 for 4 cycles → `vc_sa_grant` sequence 0001, 0010, 0001, 0010.
- **Tail release:** with VC0 bound and `tail[0]` = 1, grant it, and drive `vc_grants[0]` = 4'b1000 in the same cycle → `vc_sa_grant[0]` pulses and `vc_active[0]` falls on the same edge.
  - The row of 4'b1000 is ignored.
  - Re-driving 4'b1000 one cycle later → `vc_out_sel[0]` = 3.
- **Reset mid-packet:** bindings on VC0 and VC2 plus an active `port_grant`, then assert `reset` → next cycle all outputs are zero. A subsequent `port_grant` produces no grant until new bindings are captured.

Source files
------------

// File: rtl/port_grant_2_vc_grant.sv
`default_nettype none
// ============================================================================
// Module      : port_grant_2_vc_grant
// Description : Maps per-port switch-allocation grants back onto the input
//               virtual channels that requested them. Each input VC holds the
//               output VC it won in VC allocation until its tail flit is
//               sent. Each cycle, for every input port, the lowest granted
//               output port selects one bound, ready VC of that input port.
//               The choice is round-robin and the result is a registered
//               one-cycle send grant.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   clock for all state
//   reset        in   synchronous, active-high reset
//   vc_grants    in   [TOTAL][TOTAL] VC-allocator grants (row per input VC)
//   vc_ready     in   [TOTAL] VC has a head flit and downstream credit
//   tail         in   [TOTAL] head flit of the VC is a tail flit
//   port_grant   in   [NUM_PORTS][NUM_PORTS] switch grant (row per input port)
//   vc_sa_grant  out  [TOTAL] registered per-VC send grant
//   vc_out_sel   out  [TOTAL][IDXW] output VC bound to each input VC
//   vc_active    out  [TOTAL] input VC holds a binding
// ============================================================================
module port_grant_2_vc_grant #(
  parameter  int NUM_PORTS = 2,
  parameter  int NUM_VC    = 2,
  localparam int TOTAL     = NUM_PORTS * NUM_VC,
  localparam int IDXW      = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [TOTAL-1:0][TOTAL-1:0]       vc_grants,
  input  logic [TOTAL-1:0]                  vc_ready,
  input  logic [TOTAL-1:0]                  tail,
  input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] port_grant,
  output logic [TOTAL-1:0]                  vc_sa_grant,
  output logic [TOTAL-1:0][IDXW-1:0]        vc_out_sel,
  output logic [TOTAL-1:0]                  vc_active
);

  localparam int PTRW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } vc_state_t;

  vc_state_t                      r_state [TOTAL];
  logic [TOTAL-1:0][IDXW-1:0]     r_out_sel;
  logic [TOTAL-1:0]               r_sa_grant;
  logic [NUM_PORTS-1:0][PTRW-1:0] r_rr_ptr;

  logic [TOTAL-1:0][IDXW-1:0]     w_cap_idx;
  logic [NUM_PORTS-1:0]           w_win_vld;
  logic [NUM_PORTS-1:0][PTRW-1:0] w_win_vc;
  logic [TOTAL-1:0]               w_grant_vec;

  // Lowest set bit of each VC-allocator grant row. Rows should be one-hot,
  // scanning from the top makes the lowest bit win if they are not.
  always_comb begin
    w_cap_idx = '0;
    for (int i = 0; i < TOTAL; i++) begin
      for (int j = TOTAL - 1; j >= 0; j--) begin
        if (vc_grants[i][j]) begin
          w_cap_idx[i] = IDXW'(j);
        end
      end
    end
  end

  // Per input port: decode the lowest granted output port, then search the
  // VCs of this port starting at the round-robin pointer. The search runs
  // backwards over the offset so the smallest offset (first in round-robin
  // order) is the last assignment and therefore wins.
  always_comb begin
    w_win_vld = '0;
    w_win_vc  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      int   o_idx;
      logic o_vld;
      o_idx = 0;
      o_vld = 1'b0;
      for (int b = NUM_PORTS - 1; b >= 0; b--) begin
        if (port_grant[p][b]) begin
          o_idx = b;
          o_vld = 1'b1;
        end
      end
      for (int k = NUM_VC - 1; k >= 0; k--) begin
        int v;
        int i;
        v = (int'(r_rr_ptr[p]) + k) % NUM_VC;
        i = p * NUM_VC + v;
        if (o_vld && (r_state[i] == ACTIVE) && vc_ready[i] &&
            ((int'(r_out_sel[i]) / NUM_VC) == o_idx)) begin
          w_win_vld[p] = 1'b1;
          w_win_vc[p]  = PTRW'(v);
        end
      end
    end
  end

  // Expand the per-port winner into a flat per-VC grant vector.
  always_comb begin
    w_grant_vec = '0;
    for (int i = 0; i < TOTAL; i++) begin
      w_grant_vec[i] = w_win_vld[i / NUM_VC] &&
                       (w_win_vc[i / NUM_VC] == PTRW'(i % NUM_VC));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TOTAL; i++) begin
        r_state[i] <= IDLE;
      end
      r_out_sel  <= '0;
      r_sa_grant <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_sa_grant <= w_grant_vec;

      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_win_vld[p]) begin
          r_rr_ptr[p] <= (w_win_vc[p] == PTRW'(NUM_VC - 1)) ? '0
                                                             : w_win_vc[p] + PTRW'(1);
        end
      end

      for (int i = 0; i < TOTAL; i++) begin
        case (r_state[i])
          IDLE: begin
            if (|vc_grants[i]) begin
              r_state[i]   <= ACTIVE;
              r_out_sel[i] <= w_cap_idx[i];
            end
          end
          ACTIVE: begin
            // Release on the same edge that registers the tail flit's grant;
            // the binding index is left in place.
            if (w_grant_vec[i] && tail[i]) begin
              r_state[i] <= IDLE;
            end
          end
          default: r_state[i] <= IDLE;
        endcase
      end
    end
  end

  generate
    for (genvar gi = 0; gi < TOTAL; gi++) begin : g_active
      assign vc_active[gi] = (r_state[gi] == ACTIVE);
    end
  endgenerate

  assign vc_sa_grant = r_sa_grant;
  assign vc_out_sel  = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_port_grant_2_vc_grant.sv
`default_nettype none
// ============================================================================
// Module      : tb_port_grant_2_vc_grant
// Description : Self-checking bench for port_grant_2_vc_grant with
//               NUM_PORTS=2, NUM_VC=2. Directed scenarios followed by
//               randomized traffic, compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_port_grant_2_vc_grant;

  localparam int NP = 2;
  localparam int NV = 2;
  localparam int T  = NP * NV;
  localparam int IW = 2;

  logic                 clk;
  logic                 reset;
  logic [T-1:0][T-1:0]  vc_grants;
  logic [T-1:0]         vc_ready;
  logic [T-1:0]         tail;
  logic [NP-1:0][NP-1:0] port_grant;
  logic [T-1:0]         vc_sa_grant;
  logic [T-1:0][IW-1:0] vc_out_sel;
  logic [T-1:0]         vc_active;

  port_grant_2_vc_grant #(
    .NUM_PORTS (NP),
    .NUM_VC    (NV)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .vc_grants   (vc_grants),
    .vc_ready    (vc_ready),
    .tail        (tail),
    .port_grant  (port_grant),
    .vc_sa_grant (vc_sa_grant),
    .vc_out_sel  (vc_out_sel),
    .vc_active   (vc_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model state
  int       m_act [T];
  int       m_sel [T];
  int       m_ptr [NP];
  logic [T-1:0] m_grant;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock: compute the model's next state from the inputs the
  // DUT is about to sample, then compare all outputs after the edge.
  task automatic tick();
    int nact [T];
    int nsel [T];
    int nptr [NP];
    logic [T-1:0] g;
    logic [T-1:0] act_v;
    g = '0;
    for (int i = 0; i < T; i++) begin
      nact[i] = m_act[i];
      nsel[i] = m_sel[i];
    end
    for (int p = 0; p < NP; p++) nptr[p] = m_ptr[p];
    if (reset) begin
      for (int i = 0; i < T; i++) begin
        nact[i] = 0;
        nsel[i] = 0;
      end
      for (int p = 0; p < NP; p++) nptr[p] = 0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        int o;
        int found;
        o = -1;
        found = 0;
        for (int b = 0; b < NP; b++) if (o < 0 && port_grant[p][b]) o = b;
        if (o >= 0) begin
          for (int k = 0; k < NV; k++) begin
            int v;
            int i;
            v = (m_ptr[p] + k) % NV;
            i = p * NV + v;
            if (!found && m_act[i] == 1 && vc_ready[i] && (m_sel[i] / NV) == o) begin
              g[i] = 1'b1;
              nptr[p] = (v + 1) % NV;
              found = 1;
            end
          end
        end
      end
      for (int i = 0; i < T; i++) begin
        if (m_act[i] == 0) begin
          int lo;
          lo = -1;
          for (int j = 0; j < T; j++) if (lo < 0 && vc_grants[i][j]) lo = j;
          if (lo >= 0) begin
            nact[i] = 1;
            nsel[i] = lo;
          end
        end else if (g[i] && tail[i]) begin
          nact[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < T; i++) begin
      m_act[i] = nact[i];
      m_sel[i] = nsel[i];
      act_v[i] = (nact[i] != 0);
    end
    for (int p = 0; p < NP; p++) m_ptr[p] = nptr[p];
    m_grant = g;
    check("m_sa_grant", 32'(vc_sa_grant), 32'(m_grant));
    check("m_active", 32'(vc_active), 32'(act_v));
    for (int i = 0; i < T; i++) begin
      check($sformatf("m_out_sel%0d", i), 32'(vc_out_sel[i]), 32'(m_sel[i]));
    end
  endtask

  task automatic clear_inputs();
    vc_grants  = '0;
    vc_ready   = '0;
    tail       = '0;
    port_grant = '0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < T; i++) begin
      int r;
      r = $urandom_range(0, 7);
      vc_grants[i] = (r < T) ? T'(1 << r) : '0;
    end
    vc_ready   = T'($urandom);
    tail       = T'($urandom);
    port_grant = (NP * NP)'($urandom);
  endtask

  initial begin
    for (int i = 0; i < T; i++) begin
      m_act[i] = 0;
      m_sel[i] = 0;
    end
    for (int p = 0; p < NP; p++) m_ptr[p] = 0;
    m_grant = '0;

    // Reset with random inputs
    reset = 1'b1;
    rand_inputs();
    tick();
    rand_inputs();
    tick();
    check("rst_sa_grant", 32'(vc_sa_grant), 32'h0);
    check("rst_active", 32'(vc_active), 32'h0);
    check("rst_out_sel", 32'(vc_out_sel), 32'h0);

    // Capture
    reset = 1'b0;
    clear_inputs();
    vc_grants[0] = 4'b0001;
    vc_grants[1] = 4'b0100;
    tick();
    check("cap_active", 32'(vc_active), 32'h3);
    check("cap_sel0", 32'(vc_out_sel[0]), 32'd0);
    check("cap_sel1", 32'(vc_out_sel[1]), 32'd2);

    // Port match
    clear_inputs();
    vc_ready = 4'b0011;
    port_grant[0] = 2'b10;
    tick();
    check("pm_grant", 32'(vc_sa_grant), 32'h2);
    port_grant[0] = 2'b00;
    tick();
    check("pm_nogrant", 32'(vc_sa_grant), 32'h0);

    // Round-robin
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vc_grants[0] = 4'b0001;
    vc_grants[1] = 4'b0010;
    tick();
    clear_inputs();
    vc_ready = 4'b0011;
    port_grant[0] = 2'b01;
    tick();
    check("rr_0", 32'(vc_sa_grant), 32'h1);
    tick();
    check("rr_1", 32'(vc_sa_grant), 32'h2);
    tick();
    check("rr_2", 32'(vc_sa_grant), 32'h1);
    tick();
    check("rr_3", 32'(vc_sa_grant), 32'h2);

    // Tail release with a same-cycle VC-allocator row that must be ignored
    clear_inputs();
    vc_ready = 4'b0001;
    tail = 4'b0001;
    port_grant[0] = 2'b01;
    vc_grants[0] = 4'b1000;
    tick();
    check("tail_grant", 32'(vc_sa_grant), 32'h1);
    check("tail_active", 32'(vc_active), 32'h2);
    check("tail_sel_kept", 32'(vc_out_sel[0]), 32'd0);
    clear_inputs();
    vc_grants[0] = 4'b1000;
    tick();
    check("rebind_active", 32'(vc_active), 32'h3);
    check("rebind_sel", 32'(vc_out_sel[0]), 32'd3);

    // Reset mid-packet
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vc_grants[0] = 4'b0001;
    vc_grants[2] = 4'b0100;
    tick();
    clear_inputs();
    vc_ready = 4'b0101;
    port_grant[0] = 2'b01;
    port_grant[1] = 2'b10;
    reset = 1'b1;
    tick();
    check("mid_rst_grant", 32'(vc_sa_grant), 32'h0);
    check("mid_rst_active", 32'(vc_active), 32'h0);
    check("mid_rst_sel", 32'(vc_out_sel), 32'h0);
    reset = 1'b0;
    tick();
    check("post_rst_grant", 32'(vc_sa_grant), 32'h0);

    // Randomized traffic, occasional reset
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      reset = ($urandom_range(0, 49) == 0);
      tick();
    end

    reset = 1'b0;
    clear_inputs();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
